// File: rtl/spi_display_arbiter_pkg.sv
// Shared definitions for the SPI display arbiter.
//   - FSM state encoding (IDLE/SETUP/SHIFT/HOLD/GAP)
//   - requester index constants (REQ_CORE=0 core updates, REQ_STAT=1 status writes)
//   - req_onehot(): requester index -> one-hot gnt/done vector
// Optional feature macro used by the arbiter files: SPI_READBACK_EN.
package spi_display_arbiter_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_HOLD  = 3'd3;
  localparam state_t ST_GAP   = 3'd4;

  localparam int REQ_CORE = 0;
  localparam int REQ_STAT = 1;

  function automatic logic [1:0] req_onehot(input logic idx);
    logic [1:0] oh;
    oh           = 2'b00;
    oh[REQ_CORE] = (idx == 1'(REQ_CORE));
    oh[REQ_STAT] = (idx == 1'(REQ_STAT));
    return oh;
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 serialiser for one frame: sclk divider, rising-edge counter and
// the shift register. Driven by the arbiter FSM state; reports the divider
// terminal count and the closing falling edge of the frame.
// Optional feature: SPI_READBACK_EN (miso captured and shifted in).
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   state             arbiter FSM state
//   load, load_data   load a new frame (grant cycle)
//   miso              SPI data in
//   div_tc            divider at terminal count this cycle
//   last_fall         this cycle ends the final sclk high phase
//   sclk              SPI clock, idle low
//   mosi_bit          current MSB of the shift register
//   rx_word           shift register contents (received word after the last fall)
module spi_shift_engine
  import spi_display_arbiter_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int WORD_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  state_t            state,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              miso,
  output logic              div_tc,
  output logic              last_fall,
  output logic              sclk,
  output logic              mosi_bit,
  output logic [WORD_W-1:0] rx_word
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(WORD_W) + 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WORD_W);

  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] shreg;
  logic              in_frame;
  logic              shifting;
  logic              shift_in;

  assign in_frame  = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
  assign shifting  = (state == ST_SHIFT);
  assign div_tc    = (div_cnt == '0);
  assign last_fall = shifting && div_tc && sclk && (bit_cnt == BIT_LAST);
  assign mosi_bit  = shreg[WORD_W-1];
  assign rx_word   = shreg;

`ifdef SPI_READBACK_EN
  // miso is held from the rising edge and enters the LSB on the following
  // falling edge, so after the last fall the register holds the whole
  // received word in order.
  logic miso_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      miso_q <= 1'b0;
    end else if (shifting && div_tc && !sclk) begin
      miso_q <= miso;
    end
  end

  assign shift_in = miso_q;
`else
  logic unused_miso;
  assign unused_miso = miso;
  assign shift_in    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= DIV_RELOAD;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      shreg   <= '0;
    end else if (load) begin
      div_cnt <= DIV_RELOAD;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      shreg   <= load_data;
    end else if (in_frame) begin
      if (div_tc) begin
        div_cnt <= DIV_RELOAD;
        if (shifting) begin
          sclk <= ~sclk;
          if (!sclk) begin
            bit_cnt <= bit_cnt + 1'b1;
          end else begin
            shreg <= {shreg[WORD_W-2:0], shift_in};
          end
        end
      end else begin
        div_cnt <= div_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_display_arbiter.sv
// Round-robin arbiter sharing the SPI display bus between the core
// (requester 0) and status/diagnostic logic (requester 1). One frame per
// grant, SPI mode 0, MSB first.
// Optional feature: SPI_READBACK_EN (rdata captures the frame read on miso;
// otherwise rdata is tied 0).
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   req[1:0]          level requests, held until granted
//   wdata0, wdata1    frame data per requester, sampled in the gnt cycle
//   gnt[1:0]          one-hot grant pulse
//   done[1:0]         one-hot frame-finished pulse (coincides with ss rising)
//   busy              FSM not idle
//   rdata             last frame captured from miso
//   ss, sclk, mosi    SPI outputs (ss active-low, sclk idle low)
//   miso              SPI data in
//
// state | meaning
// IDLE  | waiting for a request; grant issued here
// SETUP | ss low, first bit on mosi, sclk low for CLK_DIV cycles
// SHIFT | sclk toggling, WORD_W bits exchanged
// HOLD  | ss still low, sclk low for CLK_DIV cycles
// GAP   | ss high for GAP_CYC cycles before the next grant
module spi_display_arbiter
  import spi_display_arbiter_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int WORD_W  = 16,
  parameter int GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [WORD_W-1:0] wdata0,
  input  logic [WORD_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic              busy,
  output logic [WORD_W-1:0] rdata,
  output logic              ss,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int GAP_W = $clog2(GAP_CYC) + 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP_CYC - 1);

  state_t            state;
  logic              last_grant;
  logic [GAP_W-1:0]  gap_cnt;
  logic              grant_valid;
  logic              grant_idx;
  logic [WORD_W-1:0] load_data;
  logic              div_tc;
  logic              last_fall;
  logic              mosi_bit;
  logic [WORD_W-1:0] rx_word;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant_valid = !rst && (state == ST_IDLE) && (req != 2'b00);
    grant_idx   = (req == 2'b11) ? ~last_grant : req[1];
  end

  assign gnt       = grant_valid ? req_onehot(grant_idx) : 2'b00;
  assign load_data = grant_idx ? wdata1 : wdata0;
  assign busy      = (state != ST_IDLE);
  assign ss        = !((state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD));
  assign mosi      = ((state == ST_SETUP) || (state == ST_SHIFT)) ? mosi_bit : 1'b0;

  spi_shift_engine #(
    .CLK_DIV (CLK_DIV),
    .WORD_W  (WORD_W)
  ) u_engine (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .load      (grant_valid),
    .load_data (load_data),
    .miso      (miso),
    .div_tc    (div_tc),
    .last_fall (last_fall),
    .sclk      (sclk),
    .mosi_bit  (mosi_bit),
    .rx_word   (rx_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      gap_cnt    <= GAP_RELOAD;
      done       <= 2'b00;
    end else begin
      done <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            state      <= ST_SETUP;
            last_grant <= grant_idx;
          end
        end
        ST_SETUP: begin
          if (div_tc) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (last_fall) state <= ST_HOLD;
        end
        ST_HOLD: begin
          // done lands in the first GAP cycle, the same cycle ss rises.
          if (div_tc) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_RELOAD;
            done    <= req_onehot(last_grant);
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if ((state == ST_HOLD) && div_tc) begin
      rdata <= rx_word;
    end
  end
`else
  logic unused_rx;
  assign unused_rx = ^rx_word;
  assign rdata     = '0;
`endif

endmodule

// File: tb/tb_spi_display_arbiter.sv
// Self-checking bench for spi_display_arbiter. A monitor samples the bus on
// the falling clk edge and records frames, grants and done pulses; an SPI
// slave model drives miso from miso_word. Expected results come from the
// arbitration rule and frame timing formulas.
module tb_spi_display_arbiter;

  localparam int CLK_DIV   = 4;
  localparam int W         = 16;
  localparam int GAP_CYC   = 2;
  localparam int FRAME_LEN = CLK_DIV * (2 * W + 2);
`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req = 2'b00;
  logic [W-1:0] wdata0 = '0;
  logic [W-1:0] wdata1 = '0;
  logic [1:0]   gnt;
  logic [1:0]   done;
  logic         busy;
  logic [W-1:0] rdata;
  logic         ss;
  logic         sclk;
  logic         mosi;
  logic         miso = 1'b0;

  always #5 clk = ~clk;

  spi_display_arbiter #(
    .CLK_DIV (CLK_DIV),
    .WORD_W  (W),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .gnt    (gnt),
    .done   (done),
    .busy   (busy),
    .rdata  (rdata),
    .ss     (ss),
    .sclk   (sclk),
    .mosi   (mosi),
    .miso   (miso)
  );

  typedef struct {
    int           start_c;
    int           end_c;
    int           len;
    logic [W-1:0] word;
    int           nrise;
  } frame_t;

  int n_pass = 0;
  int n_total = 0;
  int viol = 0;
  int cyc = 0;
  logic model_last = 1'b1;
  logic [W-1:0] miso_word = '0;

  frame_t       frames[$];
  int           gnt_cyc[$];
  logic [1:0]   gnt_val[$];
  int           done_cyc[$];
  logic [1:0]   done_val[$];

  logic prev_ss = 1'b1, prev_sclk = 1'b0;
  logic [1:0] prev_done = 2'b00;
  int low_len = 0, rises = 0, cur_start = 0, sidx = 0;
  logic [W-1:0] sh = '0;

  // Monitor + SPI slave (mode 0: next miso bit presented after each sclk fall).
  always @(negedge clk) begin
    cyc++;
    if (gnt != 2'b00) begin gnt_cyc.push_back(cyc); gnt_val.push_back(gnt); end
    if (done != 2'b00) begin
      done_cyc.push_back(cyc); done_val.push_back(done);
      if (!(ss && !prev_ss)) viol++;
      if (prev_done != 2'b00) viol++;
    end
    if (gnt != 2'b00 && done != 2'b00) viol++;
    if ($countones(gnt) > 1 || $countones(done) > 1) viol++;
    if (!ss) begin
      if (prev_ss) begin
        low_len = 0; rises = 0; sh = '0; cur_start = cyc;
        sidx = 0; miso = miso_word[W-1];
      end else if (prev_sclk && !sclk) begin
        sidx++;
        miso = (sidx < W) ? miso_word[W-1-sidx] : 1'b0;
      end
      low_len++;
      if (sclk && !prev_sclk) begin sh = {sh[W-2:0], mosi}; rises++; end
    end else if (!prev_ss) begin
      frames.push_back('{cur_start, cyc - 1, low_len, sh, rises});
    end
    prev_ss = ss; prev_sclk = sclk; prev_done = done;
  end

  function automatic logic rr_pick(input logic [1:0] r, input logic last);
    if (r[0] && r[1]) return (last == 1'b0);
    if (r[0]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_logs();
    frames.delete(); gnt_cyc.delete(); gnt_val.delete();
    done_cyc.delete(); done_val.delete();
  endtask

  task automatic set_req(input logic [1:0] r);
    @(posedge clk); #1 req = r;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1; req = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_last = 1'b1;
    clear_logs();
  endtask

  task automatic wait_gnt(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin g = gnt; break; end
    end
    n_total++;
    if (g == 2'b00) $display("FAIL gnt_timeout: no gnt within 600 cycles");
    else n_pass++;
  endtask

  task automatic wait_done(output logic [1:0] d);
    d = 2'b00;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done != 2'b00) begin d = done; break; end
    end
    n_total++;
    if (d == 2'b00) $display("FAIL done_timeout: no done within 400 cycles");
    else n_pass++;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    n_total++;
    if (!ok) $display("FAIL idle_timeout: busy still high after 2000 cycles");
    else n_pass++;
  endtask

  task automatic test_reset();
    @(posedge clk); #1 rst = 1'b1; req = 2'b00;
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({ss, sclk, mosi, busy, gnt, done} !== 8'b1000_0000)
      $display("FAIL reset_outputs: ss/sclk/mosi/busy/gnt/done got %b want 10000000",
               {ss, sclk, mosi, busy, gnt, done});
    else n_pass++;
    n_total++;
    if (rdata !== '0) $display("FAIL reset_rdata: got %h want 0000", rdata);
    else n_pass++;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({ss, sclk, busy, gnt} !== 5'b10000)
      $display("FAIL idle_after_reset: ss/sclk/busy/gnt got %b want 10000", {ss, sclk, busy, gnt});
    else n_pass++;
    clear_logs();
  endtask

  task automatic test_single_frame();
    logic [1:0] g, d;
    do_reset();
    wdata0 = 16'hA55A; wdata1 = 16'($urandom);
    set_req(2'b01);
    wait_gnt(g);
    n_total++;
    if (g !== 2'b01) $display("FAIL single_gnt: got %b want 01", g); else n_pass++;
    set_req(2'b00);
    wait_done(d);
    n_total++;
    if (d !== 2'b01) $display("FAIL single_done: got %b want 01", d); else n_pass++;
    @(posedge clk);
    n_total++;
    if (frames.size() != 1) $display("FAIL single_frames: got %0d frames want 1", frames.size());
    else begin
      if (frames[0].len == FRAME_LEN && frames[0].word === 16'hA55A && frames[0].nrise == W &&
          done_cyc[0] == frames[0].end_c + 1 && gnt_cyc[0] == frames[0].start_c - 1)
        n_pass++;
      else
        $display("FAIL single_frame: len %0d word %h rises %0d done@%0d ssend@%0d gnt@%0d start@%0d want len %0d word a55a rises %0d",
                 frames[0].len, frames[0].word, frames[0].nrise, done_cyc[0], frames[0].end_c,
                 gnt_cyc[0], frames[0].start_c, FRAME_LEN, W);
    end
  endtask

  task automatic test_round_robin();
    logic e;
    logic [W-1:0] w0, w1;
    do_reset();
    w0 = 16'($urandom); w1 = 16'($urandom);
    wdata0 = w0; wdata1 = w1;
    set_req(2'b11);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (gnt_val.size() >= 4) break;
    end
    set_req(2'b00);
    wait_idle();
    repeat (5) @(posedge clk);
    n_total++;
    if (gnt_val.size() != 4 || frames.size() != 4 || done_val.size() != 4)
      $display("FAIL rr_count: gnts %0d frames %0d dones %0d want 4", gnt_val.size(), frames.size(), done_val.size());
    else n_pass++;
    for (int k = 0; k < 4 && k < gnt_val.size() && k < frames.size() && k < done_val.size(); k++) begin
      e = rr_pick(2'b11, model_last);
      model_last = e;
      n_total++;
      if (gnt_val[k] !== (2'b01 << e) || done_val[k] !== gnt_val[k] || frames[k].word !== (e ? w1 : w0))
        $display("FAIL rr_grant%0d: gnt %b done %b word %h want gnt %b word %h",
                 k, gnt_val[k], done_val[k], frames[k].word, 2'b01 << e, e ? w1 : w0);
      else n_pass++;
      if (k > 0) begin
        n_total++;
        if (gnt_cyc[k] - done_cyc[k-1] != GAP_CYC)
          $display("FAIL rr_spacing%0d: gnt %0d cycles after done want %0d", k, gnt_cyc[k] - done_cyc[k-1], GAP_CYC);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wdata1 = 16'h00FF; wdata0 = 16'($urandom);
    set_req(2'b10);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frames.size() >= 3) break;
    end
    set_req(2'b00);
    wait_idle();
    n_total++;
    if (frames.size() < 3) $display("FAIL b2b_count: got %0d frames want 3", frames.size());
    else n_pass++;
    for (int k = 0; k < 3 && k < frames.size(); k++) begin
      n_total++;
      if (frames[k].word !== 16'h00FF || frames[k].len != FRAME_LEN || done_val[k] !== 2'b10)
        $display("FAIL b2b_frame%0d: word %h len %0d done %b want 00ff %0d 10",
                 k, frames[k].word, frames[k].len, done_val[k], FRAME_LEN);
      else n_pass++;
      if (k > 0) begin
        n_total++;
        if (frames[k].start_c - frames[k-1].end_c - 1 != GAP_CYC + 1)
          $display("FAIL b2b_ss_high%0d: got %0d cycles want %0d",
                   k, frames[k].start_c - frames[k-1].end_c - 1, GAP_CYC + 1);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [1:0] g, d;
    logic p;
    int r;
    logic [W-1:0] w;
    do_reset();
    wdata0 = 16'($urandom);
    set_req(2'b01);
    wait_gnt(g);
    set_req(2'b00);
    r = 0; p = sclk;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (sclk && !p) r++;
      p = sclk;
      if (r == 7) break;
    end
    n_total++;
    if (r != 7) $display("FAIL mid_rises: saw %0d sclk rises want 7", r); else n_pass++;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_last = 1'b1;
    @(negedge clk);
    n_total++;
    if ({ss, sclk, mosi, done, busy} !== 6'b100000)
      $display("FAIL mid_reset_outputs: ss/sclk/mosi/done/busy got %b want 100000", {ss, sclk, mosi, done, busy});
    else n_pass++;
    clear_logs();
    repeat (200) @(negedge clk);
    n_total++;
    if (done_val.size() != 0 || gnt_val.size() != 0)
      $display("FAIL mid_no_done: dones %0d gnts %0d want 0", done_val.size(), gnt_val.size());
    else n_pass++;
    clear_logs();
    w = 16'($urandom); wdata0 = w;
    set_req(2'b01);
    wait_gnt(g);
    n_total++;
    if (g !== 2'b01) $display("FAIL mid_regrant: got %b want 01", g); else n_pass++;
    set_req(2'b00);
    wait_done(d);
    @(posedge clk);
    n_total++;
    if (frames.size() != 1 || frames[0].word !== w || frames[0].nrise != W || frames[0].len != FRAME_LEN)
      $display("FAIL mid_full_frame: frames %0d word %h want %h", frames.size(),
               frames.size() > 0 ? frames[0].word : 16'h0, w);
    else n_pass++;
    // Requester 0 won last; a reset must make it first again on a tie.
    set_req(2'b01);
    wait_gnt(g);
    set_req(2'b00);
    repeat (50) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    set_req(2'b11);
    wait_gnt(g);
    n_total++;
    if (g !== 2'b01) $display("FAIL mid_last_grant: tie after reset got %b want 01", g); else n_pass++;
    set_req(2'b00);
    wait_idle();
  endtask

  task automatic test_readback();
    logic [1:0] g, d;
    logic [W-1:0] e;
    do_reset();
    miso_word = 16'h3C0F; wdata0 = 16'($urandom);
    set_req(2'b01);
    wait_gnt(g);
    set_req(2'b00);
    wait_done(d);
    e = RB ? 16'h3C0F : 16'h0000;
    n_total++;
    if (rdata !== e) $display("FAIL readback_done: rdata %h want %h", rdata, e); else n_pass++;
    repeat (10) @(negedge clk);
    n_total++;
    if (rdata !== e) $display("FAIL readback_hold: rdata %h want %h", rdata, e); else n_pass++;
    miso_word = 16'($urandom); wdata1 = 16'($urandom);
    set_req(2'b10);
    wait_gnt(g);
    set_req(2'b00);
    wait_done(d);
    e = RB ? miso_word : 16'h0000;
    n_total++;
    if (rdata !== e) $display("FAIL readback_second: rdata %h want %h", rdata, e); else n_pass++;
  endtask

  task automatic test_drop_req();
    logic [1:0] g;
    do_reset();
    wdata1 = 16'($urandom);
    set_req(2'b10);
    wait_gnt(g);
    set_req(2'b00);
    repeat (30) @(negedge clk);
    set_req(2'b01);
    repeat (4) @(posedge clk);
    set_req(2'b00);
    wait_idle();
    repeat (20) @(negedge clk);
    n_total++;
    if (gnt_val.size() != 1 || gnt_val[0] !== 2'b10 || done_val.size() != 1 || busy !== 1'b0)
      $display("FAIL drop_req: gnts %0d first %b dones %0d busy %b want 1 10 1 0",
               gnt_val.size(), gnt_val.size() > 0 ? gnt_val[0] : 2'b00, done_val.size(), busy);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] g, d, r;
    logic e;
    logic [W-1:0] w0, w1, ex;
    do_reset();
    for (int it = 0; it < 8; it++) begin
      clear_logs();
      r = 2'($urandom_range(1, 3));
      w0 = 16'($urandom); w1 = 16'($urandom); miso_word = 16'($urandom);
      wdata0 = w0; wdata1 = w1;
      set_req(r);
      wait_gnt(g);
      e = rr_pick(r, model_last);
      model_last = e;
      n_total++;
      if (g !== (2'b01 << e)) $display("FAIL rand_gnt%0d: req %b got %b want %b", it, r, g, 2'b01 << e);
      else n_pass++;
      set_req(2'b00);
      wait_done(d);
      ex = RB ? miso_word : 16'h0000;
      n_total++;
      if (d !== (2'b01 << e) || rdata !== ex)
        $display("FAIL rand_done%0d: done %b rdata %h want %b %h", it, d, rdata, 2'b01 << e, ex);
      else n_pass++;
      @(posedge clk);
      n_total++;
      if (frames.size() != 1 || frames[0].word !== (e ? w1 : w0) || frames[0].len != FRAME_LEN)
        $display("FAIL rand_frame%0d: frames %0d word %h want %h", it, frames.size(),
                 frames.size() > 0 ? frames[0].word : 16'h0, e ? w1 : w0);
      else n_pass++;
    end
  endtask

  task automatic test_invariants();
    n_total++;
    if (viol != 0) $display("FAIL invariants: %0d gnt/done pulse violations want 0", viol);
    else n_pass++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached after %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_back_to_back();
    test_reset_mid_frame();
    test_readback();
    test_drop_req();
    test_random();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
